fp_cvt_arb: RTL and testbench

//  Shares one fp_cvt conversion unit (f2i + i2f with rounding, fixed latency LAT) between two requesters.

---
 rtl/fp_cvt_arb.sv | 198 +++++++++++++++++++
 tb/tb_fp_cvt_arb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_cvt_arb.sv
// Two-requester front end for a shared fixed-latency fp_cvt unit: round-robin issue,
// in-flight tag tracking and per-requester response FIFOs with credit-gated acceptance.
module fp_cvt_arb #(
  parameter int LAT  = 2,
  parameter int TAGW = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic            r0_f2i,
  input  logic [1:0]      r0_op,
  input  logic [2:0]      r0_rm,
  input  logic [32:0]     r0_data,
  input  logic [TAGW-1:0] r0_tag,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic            r1_f2i,
  input  logic [1:0]      r1_op,
  input  logic [2:0]      r1_rm,
  input  logic [32:0]     r1_data,
  input  logic [TAGW-1:0] r1_tag,
  output logic            u_valid,
  output logic            u_f2i,
  output logic [1:0]      u_op,
  output logic [2:0]      u_rm,
  output logic [32:0]     u_data,
  input  logic            u_res_valid,
  input  logic [31:0]     u_res,
  input  logic [4:0]      u_flags,
  output logic            s0_valid,
  input  logic            s0_ready,
  output logic [31:0]     s0_result,
  output logic [4:0]      s0_flags,
  output logic [TAGW-1:0] s0_tag,
  output logic            s1_valid,
  input  logic            s1_ready,
  output logic [31:0]     s1_result,
  output logic [4:0]      s1_flags,
  output logic [TAGW-1:0] s1_tag,
  output logic            err
);
  localparam int DEPTH = LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int WW    = $clog2(LAT + 2);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [1:0]      credit, elig, grant, push, pop;
  logic            ptr;
  logic            vld_p1, f2i_p1, id_p1;
  logic [1:0]      op_p1;
  logic [2:0]      rm_p1;
  logic [32:0]     data_p1;
  logic [TAGW-1:0] tag_p1;
  logic            trk_v   [LAT];
  logic            trk_id  [LAT];
  logic [TAGW-1:0] trk_tag [LAT];
  logic [31:0]     f_res [2][DEPTH];
  logic [4:0]      f_flg [2][DEPTH];
  logic [TAGW-1:0] f_tag [2][DEPTH];
  logic [PW-1:0]   rd_ptr [2];
  logic [PW-1:0]   wr_ptr [2];
  logic [CW-1:0]   occ [2];
  logic [CW-1:0]   infl [2];
  logic [WW-1:0]   warm;
  logic            warm_on, out_v, out_id, res_ok, err_set;

  // Outstanding work per requester = FIFO entries + issue register + track entries.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      infl[n] = '0;
      if (vld_p1 && id_p1 == 1'(n)) infl[n] = infl[n] + CW'(1);
      for (int k = 0; k < LAT; k++)
        if (trk_v[k] && trk_id[k] == 1'(n)) infl[n] = infl[n] + CW'(1);
      credit[n] = (int'(occ[n]) + int'(infl[n])) < DEPTH;
    end
  end

  assign elig     = {r1_valid, r0_valid} & credit;
  assign grant[0] = elig[0] & (~elig[1] | ~ptr);
  assign grant[1] = elig[1] & (~elig[0] | ptr);
  assign r0_ready = grant[0];
  assign r1_ready = grant[1];

  // Stage p1: issue register feeding the shared unit
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr     <= 1'b0;
      vld_p1  <= 1'b0;
      id_p1   <= 1'b0;
      f2i_p1  <= 1'b0;
      op_p1   <= '0;
      rm_p1   <= '0;
      data_p1 <= '0;
      tag_p1  <= '0;
    end else begin
      vld_p1 <= |grant;
      if (|grant) begin
        ptr     <= grant[0];
        id_p1   <= grant[1];
        f2i_p1  <= grant[1] ? r1_f2i  : r0_f2i;
        op_p1   <= grant[1] ? r1_op   : r0_op;
        rm_p1   <= grant[1] ? r1_rm   : r0_rm;
        data_p1 <= grant[1] ? r1_data : r0_data;
        tag_p1  <= grant[1] ? r1_tag  : r0_tag;
      end
    end
  end

  assign u_valid = vld_p1;
  assign u_f2i   = f2i_p1;
  assign u_op    = op_p1;
  assign u_rm    = rm_p1;
  assign u_data  = data_p1;

  // Track stages: last entry lines up with the unit's result strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) begin
        trk_v[k]   <= 1'b0;
        trk_id[k]  <= 1'b0;
        trk_tag[k] <= '0;
      end
    end else begin
      trk_v[0]   <= vld_p1;
      trk_id[0]  <= id_p1;
      trk_tag[0] <= tag_p1;
      for (int k = 1; k < LAT; k++) begin
        trk_v[k]   <= trk_v[k-1];
        trk_id[k]  <= trk_id[k-1];
        trk_tag[k] <= trk_tag[k-1];
      end
    end
  end

  // Results from work issued before reset may still arrive during the warm-up window.
  assign warm_on = (warm != WW'(LAT + 1));
  assign out_v   = trk_v[LAT-1];
  assign out_id  = trk_id[LAT-1];
  assign res_ok  = u_res_valid & ~warm_on;
  assign err_set = (res_ok & ~out_v) | (out_v & ~u_res_valid);
  assign push[0] = res_ok & out_v & ~out_id;
  assign push[1] = res_ok & out_v & out_id;
  assign pop[0]  = s0_ready & s0_valid;
  assign pop[1]  = s1_ready & s1_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      warm <= '0;
      err  <= 1'b0;
    end else begin
      if (warm_on) warm <= warm + WW'(1);
      if (err_set) err <= 1'b1;
    end
  end

  // Response FIFOs
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        rd_ptr[n] <= '0;
        wr_ptr[n] <= '0;
        occ[n]    <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          f_res[n][d] <= '0;
          f_flg[n][d] <= '0;
          f_tag[n][d] <= '0;
        end
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) begin
          f_res[n][wr_ptr[n]] <= u_res;
          f_flg[n][wr_ptr[n]] <= u_flags;
          f_tag[n][wr_ptr[n]] <= trk_tag[LAT-1];
          wr_ptr[n]           <= ptr_inc(wr_ptr[n]);
        end
        if (pop[n]) rd_ptr[n] <= ptr_inc(rd_ptr[n]);
        if (push[n] && !pop[n])      occ[n] <= occ[n] + CW'(1);
        else if (!push[n] && pop[n]) occ[n] <= occ[n] - CW'(1);
      end
    end
  end

  assign s0_valid  = (occ[0] != '0);
  assign s0_result = f_res[0][rd_ptr[0]];
  assign s0_flags  = f_flg[0][rd_ptr[0]];
  assign s0_tag    = f_tag[0][rd_ptr[0]];
  assign s1_valid  = (occ[1] != '0);
  assign s1_result = f_res[1][rd_ptr[1]];
  assign s1_flags  = f_flg[1][rd_ptr[1]];
  assign s1_tag    = f_tag[1][rd_ptr[1]];

endmodule

// File: tb/tb_fp_cvt_arb.sv
// Bench for fp_cvt_arb: delay-line model of the shared unit plus a transaction-level
// scoreboard (outstanding counts, round-robin pointer, per-requester result queues).
module tb_fp_cvt_arb;
  localparam int LAT   = 2;
  localparam int TAGW  = 4;
  localparam int DEPTH = LAT + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic r0_valid, r0_ready, r0_f2i, r1_valid, r1_ready, r1_f2i;
  logic [1:0] r0_op, r1_op;
  logic [2:0] r0_rm, r1_rm;
  logic [32:0] r0_data, r1_data;
  logic [TAGW-1:0] r0_tag, r1_tag;
  logic u_valid, u_f2i, u_res_valid;
  logic [1:0] u_op;
  logic [2:0] u_rm;
  logic [32:0] u_data;
  logic [31:0] u_res;
  logic [4:0] u_flags;
  logic s0_valid, s0_ready, s1_valid, s1_ready, err;
  logic [31:0] s0_result, s1_result;
  logic [4:0] s0_flags, s1_flags;
  logic [TAGW-1:0] s0_tag, s1_tag;

  always #5 clock = ~clock;

  fp_cvt_arb #(.LAT(LAT), .TAGW(TAGW)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_f2i(r0_f2i), .r0_op(r0_op),
    .r0_rm(r0_rm), .r0_data(r0_data), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_f2i(r1_f2i), .r1_op(r1_op),
    .r1_rm(r1_rm), .r1_data(r1_data), .r1_tag(r1_tag),
    .u_valid(u_valid), .u_f2i(u_f2i), .u_op(u_op), .u_rm(u_rm), .u_data(u_data),
    .u_res_valid(u_res_valid), .u_res(u_res), .u_flags(u_flags),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_result(s0_result),
    .s0_flags(s0_flags), .s0_tag(s0_tag),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_result(s1_result),
    .s1_flags(s1_flags), .s1_tag(s1_tag),
    .err(err)
  );

  // Shared unit: LAT-cycle delay, optionally swallowing one result strobe.
  bit          uv_pipe [LAT];
  bit          ud_pipe [LAT];
  logic [31:0] ur_pipe [LAT];
  int drop_req  = 0;
  int drop_done = 0;

  always @(posedge clock) begin
    uv_pipe[0] <= (u_valid === 1'b1) && (drop_req == drop_done);
    ud_pipe[0] <= (u_valid === 1'b1) && (drop_req != drop_done);
    if (u_valid === 1'b1 && drop_req != drop_done) drop_done <= drop_done + 1;
    ur_pipe[0] <= u_data[31:0] ^ 32'hA5A5A5A5;
    for (int k = 1; k < LAT; k++) begin
      uv_pipe[k] <= uv_pipe[k-1];
      ud_pipe[k] <= ud_pipe[k-1];
      ur_pipe[k] <= ur_pipe[k-1];
    end
  end

  assign u_res_valid = uv_pipe[LAT-1];
  assign u_res       = ur_pipe[LAT-1];
  assign u_flags     = 5'b00001;

  typedef struct {
    logic [40:0] val;
    int          t;
  } ent_t;

  ent_t sq [2][$];
  int   outst [2];
  int   acc [2];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   ptr_m = 1'b0;
  bit   chk_s = 1'b1;
  logic exp_uv = 1'b0;
  logic exp_err = 1'b0;
  logic [38:0] exp_uf = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v0, input bit v1, input bit k0, input bit k1);
    r0_valid = v0;  r1_valid = v1;
    s0_ready = k0;  s1_ready = k1;
    r0_f2i  = 1'($urandom);  r1_f2i  = 1'($urandom);
    r0_op   = 2'($urandom);  r1_op   = 2'($urandom);
    r0_rm   = 3'($urandom_range(0, 4));
    r1_rm   = 3'($urandom_range(0, 4));
    r0_data = {1'($urandom), $urandom};
    r1_data = {1'($urandom), $urandom};
    r0_tag  = TAGW'(acc[0]);
    r1_tag  = TAGW'(acc[1]);
  endtask

  // Check the current cycle at the falling edge, then advance the reference model.
  task automatic tick();
    logic [1:0] rv, sk, el, g, vis;
    ent_t e;
    @(negedge clock);
    if (!reset) begin
      rv = {r1_valid, r0_valid};
      sk = {s1_ready, s0_ready};
      for (int n = 0; n < 2; n++) begin
        el[n]  = rv[n] && (outst[n] < DEPTH);
        vis[n] = (sq[n].size() > 0) && (sq[n][0].t <= cyc);
      end
      g[0] = el[0] && (!el[1] || !ptr_m);
      g[1] = el[1] && (!el[0] || ptr_m);
      chk("r0_ready", r0_ready, g[0]);
      chk("r1_ready", r1_ready, g[1]);
      chk("u_valid", u_valid, exp_uv);
      if (exp_uv) chk("u_fields", {u_f2i, u_op, u_rm, u_data}, exp_uf);
      chk("err", err, exp_err);
      if (chk_s) begin
        chk("s0_valid", s0_valid, vis[0]);
        if (vis[0]) chk("s0_head", {s0_result, s0_flags, s0_tag}, sq[0][0].val);
        chk("s1_valid", s1_valid, vis[1]);
        if (vis[1]) chk("s1_head", {s1_result, s1_flags, s1_tag}, sq[1][0].val);
      end
      exp_uv = |g;
      if (g[0]) begin
        exp_uf = {r0_f2i, r0_op, r0_rm, r0_data};
        e.val = {r0_data[31:0] ^ 32'hA5A5A5A5, 5'b00001, r0_tag};
        e.t = cyc + 2 + LAT;
        sq[0].push_back(e);
        outst[0]++;  acc[0]++;  ptr_m = 1'b1;
      end else if (g[1]) begin
        exp_uf = {r1_f2i, r1_op, r1_rm, r1_data};
        e.val = {r1_data[31:0] ^ 32'hA5A5A5A5, 5'b00001, r1_tag};
        e.t = cyc + 2 + LAT;
        sq[1].push_back(e);
        outst[1]++;  acc[1]++;  ptr_m = 1'b0;
      end
      for (int n = 0; n < 2; n++)
        if (vis[n] && sk[n]) begin
          void'(sq[n].pop_front());
          outst[n]--;
        end
      if (ud_pipe[LAT-1]) exp_err = 1'b1;
    end else begin
      for (int n = 0; n < 2; n++) begin
        sq[n].delete();
        outst[n] = 0;
      end
      ptr_m = 1'b0;  exp_uv = 1'b0;  exp_err = 1'b0;
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    outst[0] = 0; outst[1] = 0; acc[0] = 0; acc[1] = 0;

    // Reset state
    drive(0, 0, 0, 0);
    repeat (5) tick();
    reset = 1'b0;
    chk("rst_u_valid", u_valid, 1'b0);
    chk("rst_u_data", u_data, 33'h0);
    chk("rst_s0_valid", s0_valid, 1'b0);
    chk("rst_s1_valid", s1_valid, 1'b0);
    chk("rst_err", err, 1'b0);

    // Single r0 conversion with known data
    drive(1, 0, 1, 1);
    r0_data = 33'h0_3F80_0000;
    r0_tag  = 4'd3;
    tick();
    chk("t1_u_valid", u_valid, 1'b1);
    chk("t1_u_data", u_data, 33'h0_3F80_0000);
    drive(0, 0, 1, 1);
    repeat (LAT) tick();
    chk("t1_s0_early", s0_valid, 1'b0);
    tick();
    chk("t1_s0_valid", s0_valid, 1'b1);
    chk("t1_s0_result", s0_result, 32'h9A25A5A5);
    chk("t1_s0_tag", s0_tag, 4'd3);
    chk("t1_s0_flags", s0_flags, 5'b00001);
    repeat (3) tick();

    // Both requesters every cycle
    a0 = acc[0]; a1 = acc[1];
    repeat (16) begin drive(1, 1, 1, 1); tick(); end
    chk("t2_acc0", acc[0] - a0, 8);
    chk("t2_acc1", acc[1] - a1, 8);
    drive(0, 0, 1, 1);
    repeat (8) tick();
    chk("t2_drain0", s0_valid, 1'b0);
    chk("t2_drain1", s1_valid, 1'b0);

    // s1 consumer stalled
    a1 = acc[1];
    repeat (14) begin drive(1, 1, 1, 0); tick(); end
    chk("t3_acc1", acc[1] - a1, DEPTH);
    drive(0, 0, 1, 1);
    repeat (10) tick();
    chk("t3_left1", sq[1].size(), 0);
    chk("t3_drain1", s1_valid, 1'b0);

    // s0 FIFO filled, then pop coinciding with a return
    a0 = acc[0];
    repeat (8) begin drive(1, 0, 0, 1); tick(); end
    chk("t6_fill", acc[0] - a0, DEPTH);
    drive(1, 0, 1, 1); tick();
    repeat (LAT + 1) begin drive(1, 0, 0, 1); tick(); end
    drive(0, 0, 1, 1);
    chk("t6_head_before", s0_valid, 1'b1);
    tick();
    chk("t6_head_after", s0_valid, 1'b1);
    repeat (2) begin drive(1, 0, 0, 1); tick(); end
    drive(0, 0, 1, 1);
    repeat (10) tick();
    chk("t6_drain", s0_valid, 1'b0);

    // Dropped result strobe
    drop_req = drop_req + 1;
    drive(1, 0, 1, 1);
    tick();
    chk_s = 1'b0;
    drive(0, 0, 1, 1);
    repeat (LAT + 3) tick();
    chk("t4_err_set", err, 1'b1);
    repeat (3) tick();
    chk("t4_err_sticky", err, 1'b1);

    // Reset with work in flight
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_s = 1'b1;
    chk("t5_err_clear", err, 1'b0);
    drive(1, 1, 1, 1);
    repeat (2) tick();
    reset = 1'b1;
    drive(0, 0, 1, 1);
    tick();
    reset = 1'b0;
    chk("t5_u_valid", u_valid, 1'b0);
    chk("t5_u_data", u_data, 33'h0);
    chk("t5_s0_valid", s0_valid, 1'b0);
    chk("t5_s1_valid", s1_valid, 1'b0);
    repeat (LAT + 3) tick();
    chk("t5_err_quiet", err, 1'b0);

    // Random traffic
    repeat (400) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      tick();
    end
    drive(0, 0, 1, 1);
    repeat (12) tick();
    chk("rand_left0", sq[0].size(), 0);
    chk("rand_left1", sq[1].size(), 0);
    chk("rand_s0_empty", s0_valid, 1'b0);
    chk("rand_s1_empty", s1_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
